alu_share_arbiter: RTL and testbench

Multi-requester front end for the 32-bit ALU. It accepts operation requests from up to NREQ clients over valid/ready handshakes and grants them in round-robin order. It drives the single shared ALU from registered operands and returns the registered result and flags to the granted client. It sits between the pipeline/functional-unit clients and the ALU instance, and is the only block allowed to drive the ALU inputs.

---
 rtl/alu_share_arbiter.sv | 176 +++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Brief    : Round-robin front end that shares one 32-bit ALU among NREQ
//            valid/ready clients, one operation in flight at a time.
// Revision : 1.0
// ============================================================================
module alu_share_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NREQ-1:0]     req_valid_i,
    output logic [NREQ-1:0]     req_ready_o,
    input  logic [NREQ*DW-1:0]  req_src1_i,
    input  logic [NREQ*DW-1:0]  req_src2_i,
    input  logic [NREQ*4-1:0]   req_ctrl_i,
    output logic                alu_rst_n_o,
    output logic [DW-1:0]       alu_src1_o,
    output logic [DW-1:0]       alu_src2_o,
    output logic [3:0]          alu_ctrl_o,
    input  logic [DW-1:0]       alu_result_i,
    input  logic                alu_zero_i,
    input  logic                alu_cout_i,
    input  logic                alu_overflow_i,
    output logic [NREQ-1:0]     rsp_valid_o,
    input  logic [NREQ-1:0]     rsp_ready_i,
    output logic [DW-1:0]       rsp_result_o,
    output logic                rsp_zero_o,
    output logic                rsp_cout_o,
    output logic                rsp_overflow_o,
    output logic                rsp_err_o
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      r_owner;
    logic [DW-1:0]      r_src1;
    logic [DW-1:0]      r_src2;
    logic [3:0]         r_ctrl;
    logic               r_illegal;
    logic [NREQ-1:0]    r_rsp_valid;
    logic [DW-1:0]      r_result;
    logic               r_zero;
    logic               r_cout;
    logic               r_overflow;
    logic               r_err;

    logic               w_any;
    logic [IW-1:0]      w_win;
    logic [NREQ-1:0]    w_ready;
    logic [NREQ-1:0]    w_owner_oh;
    logic [DW-1:0]      w_src1;
    logic [DW-1:0]      w_src2;
    logic [3:0]         w_ctrl;
    logic               w_legal;

    // Scan offsets from highest to lowest so the closest valid bit at or
    // after the pointer is the one left standing.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid_i[(int'(r_ptr) + i) % NREQ]) begin
                w_any = 1'b1;
                w_win = IW'((int'(r_ptr) + i) % NREQ);
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (r_state == S_IDLE && w_any && !rst_i) begin
            w_ready[w_win] = 1'b1;
        end
    end

    always_comb begin
        w_owner_oh          = '0;
        w_owner_oh[r_owner] = 1'b1;
    end

    assign w_src1 = req_src1_i[w_win*DW +: DW];
    assign w_src2 = req_src2_i[w_win*DW +: DW];
    assign w_ctrl = req_ctrl_i[w_win*4 +: 4];

    always_comb begin
        case (w_ctrl)
            4'b0000, 4'b0001, 4'b0010, 4'b0110,
            4'b0111, 4'b1100, 4'b1101: w_legal = 1'b1;
            default:                   w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_src1      <= '0;
            r_src2      <= '0;
            r_ctrl      <= 4'b0000;
            r_illegal   <= 1'b0;
            r_rsp_valid <= '0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_cout      <= 1'b0;
            r_overflow  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_src1    <= w_src1;
                        r_src2    <= w_src2;
                        // Illegal codes run the ALU as a harmless AND.
                        r_ctrl    <= w_legal ? w_ctrl : 4'b0000;
                        r_illegal <= ~w_legal;
                        r_owner   <= w_win;
                        r_state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_illegal) begin
                        r_result   <= '0;
                        r_zero     <= 1'b1;
                        r_cout     <= 1'b0;
                        r_overflow <= 1'b0;
                        r_err      <= 1'b1;
                    end else begin
                        r_result   <= alu_result_i;
                        r_zero     <= alu_zero_i;
                        r_cout     <= alu_cout_i;
                        r_overflow <= alu_overflow_i;
                        r_err      <= 1'b0;
                    end
                    r_rsp_valid <= w_owner_oh;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready_i[r_owner]) begin
                        r_rsp_valid <= '0;
                        r_ptr       <= (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o    = w_ready;
    assign alu_rst_n_o    = ~rst_i;
    assign alu_src1_o     = r_src1;
    assign alu_src2_o     = r_src2;
    assign alu_ctrl_o     = r_ctrl;
    assign rsp_valid_o    = r_rsp_valid;
    assign rsp_result_o   = r_result;
    assign rsp_zero_o     = r_zero;
    assign rsp_cout_o     = r_cout;
    assign rsp_overflow_o = r_overflow;
    assign rsp_err_o      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arbiter
// Brief    : Directed scoreboard bench for alu_share_arbiter with an ALU model.
// Revision : 1.0
// ============================================================================
module tb_alu_share_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;

    logic                clk = 1'b0;
    logic                rst_i;
    logic [NREQ-1:0]     req_valid_i;
    logic [NREQ-1:0]     req_ready_o;
    logic [NREQ*DW-1:0]  req_src1_i;
    logic [NREQ*DW-1:0]  req_src2_i;
    logic [NREQ*4-1:0]   req_ctrl_i;
    logic                alu_rst_n_o;
    logic [DW-1:0]       alu_src1_o;
    logic [DW-1:0]       alu_src2_o;
    logic [3:0]          alu_ctrl_o;
    logic [DW-1:0]       alu_result_i;
    logic                alu_zero_i;
    logic                alu_cout_i;
    logic                alu_overflow_i;
    logic [NREQ-1:0]     rsp_valid_o;
    logic [NREQ-1:0]     rsp_ready_i;
    logic [DW-1:0]       rsp_result_o;
    logic                rsp_zero_o;
    logic                rsp_cout_o;
    logic                rsp_overflow_o;
    logic                rsp_err_o;

    alu_share_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_src1_i     (req_src1_i),
        .req_src2_i     (req_src2_i),
        .req_ctrl_i     (req_ctrl_i),
        .alu_rst_n_o    (alu_rst_n_o),
        .alu_src1_o     (alu_src1_o),
        .alu_src2_o     (alu_src2_o),
        .alu_ctrl_o     (alu_ctrl_o),
        .alu_result_i   (alu_result_i),
        .alu_zero_i     (alu_zero_i),
        .alu_cout_i     (alu_cout_i),
        .alu_overflow_i (alu_overflow_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_result_o   (rsp_result_o),
        .rsp_zero_o     (rsp_zero_o),
        .rsp_cout_o     (rsp_cout_o),
        .rsp_overflow_o (rsp_overflow_o),
        .rsp_err_o      (rsp_err_o)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the shared ALU.
    always_comb begin
        logic [32:0] t;
        t              = '0;
        alu_cout_i     = 1'b0;
        alu_overflow_i = 1'b0;
        case (alu_ctrl_o)
            4'b0000: alu_result_i = alu_src1_o & alu_src2_o;
            4'b0001: alu_result_i = alu_src1_o | alu_src2_o;
            4'b0010: begin
                t              = {1'b0, alu_src1_o} + {1'b0, alu_src2_o};
                alu_result_i   = t[31:0];
                alu_cout_i     = t[32];
                alu_overflow_i = (alu_src1_o[31] == alu_src2_o[31]) && (t[31] != alu_src1_o[31]);
            end
            4'b0110: begin
                t              = {1'b0, alu_src1_o} + {1'b0, ~alu_src2_o} + 33'd1;
                alu_result_i   = t[31:0];
                alu_cout_i     = t[32];
                alu_overflow_i = (alu_src1_o[31] != alu_src2_o[31]) && (t[31] != alu_src1_o[31]);
            end
            4'b0111: alu_result_i = {31'd0, $signed(alu_src1_o) < $signed(alu_src2_o)};
            4'b1100: alu_result_i = ~(alu_src1_o | alu_src2_o);
            4'b1101: alu_result_i = ~(alu_src1_o & alu_src2_o);
            default: alu_result_i = 32'hDEAD_BEEF;
        endcase
        alu_zero_i = (alu_result_i == 32'd0);
    end

    typedef struct {
        int          owner;
        logic [31:0] res;
        logic        z;
        logic        ov;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_rsp();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty_at_rsp", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("rsp_valid", 32'(rsp_valid_o), 32'(1 << e.owner));
            chk("rsp_result", rsp_result_o, e.res);
            chk("rsp_zero", 32'(rsp_zero_o), 32'(e.z));
            chk("rsp_ovf", 32'(rsp_overflow_o), 32'(e.ov));
            chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
            chk("ready_in_resp", 32'(req_ready_o), 32'd0);
        end
    endtask

    // Raise requester k, expect it to win this cycle, then check EXEC and
    // the first response cycle. Returns positioned in the RESP cycle.
    task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] c, input logic [3:0] c_alu, input logic [31:0] res,
                          input logic z, input logic ov, input logic err, input bit keep);
        exp_t e;
        req_src1_i[k*DW +: DW] = a;
        req_src2_i[k*DW +: DW] = b;
        req_ctrl_i[k*4 +: 4]   = c;
        req_valid_i[k]         = 1'b1;
        #1;
        chk($sformatf("grant_%0d", k), 32'(req_ready_o), 32'(1 << k));
        e.owner = k; e.res = res; e.z = z; e.ov = ov; e.err = err;
        sb.push_back(e);
        tick();
        if (!keep) req_valid_i[k] = 1'b0;
        req_src1_i[k*DW +: DW] = 32'h1234_5678;
        #1;
        chk("exec_ready", 32'(req_ready_o), 32'd0);
        chk("exec_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("exec_src1", alu_src1_o, a);
        chk("exec_src2", alu_src2_o, b);
        chk("exec_ctrl", 32'(alu_ctrl_o), 32'(c_alu));
        tick();
        check_rsp();
        if (keep) req_src1_i[k*DW +: DW] = a;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i       = 1'b1;
        req_valid_i = '1;
        rsp_ready_i = '0;
        req_src1_i  = '0;
        req_src2_i  = '0;
        req_ctrl_i  = '0;
        tick();
        tick();
        chk("rst_ready_forced", 32'(req_ready_o), 32'd0);
        chk("rst_alu_rst_n", 32'(alu_rst_n_o), 32'd0);
        rst_i       = 1'b0;
        req_valid_i = '0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_src1", alu_src1_o, 32'd0);
        chk("rst_ctrl", 32'(alu_ctrl_o), 32'd0);
        chk("rst_err", 32'(rsp_err_o), 32'd0);
        chk("rst_result", rsp_result_o, 32'd0);
        chk("alu_rst_n_idle", 32'(alu_rst_n_o), 32'd1);

        // Round robin: all valid, SUB of equal operands, back-to-back issue.
        rsp_ready_i = '1;
        for (int k = 0; k < NREQ; k++) begin
            req_src1_i[k*DW +: DW] = 32'h1111_1111 * k + 32'd5;
            req_src2_i[k*DW +: DW] = 32'h1111_1111 * k + 32'd5;
            req_ctrl_i[k*4 +: 4]   = 4'b0110;
        end
        req_valid_i = '1;
        for (int g = 0; g < 5; g++) begin
            run_op(g % NREQ, 32'h1111_1111 * (g % NREQ) + 32'd5, 32'h1111_1111 * (g % NREQ) + 32'd5,
                   4'b0110, 4'b0110, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
            tick();
        end
        req_valid_i = '0;
        tick();

        // Single ADD with signed overflow.
        run_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, 4'b0010, 32'h8000_0000,
               1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("add_rsp_drop", 32'(rsp_valid_o), 32'd0);

        // Backpressure on requester 2; non-owner ready bits are high.
        rsp_ready_i = '0;
        run_op(2, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0111, 4'b0111, 32'd1,
               1'b0, 1'b0, 1'b0, 1'b0);
        req_valid_i[0] = 1'b1;
        rsp_ready_i    = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 32'(rsp_valid_o), 32'b0100);
            chk("bp_result", rsp_result_o, 32'd1);
            chk("bp_ready", 32'(req_ready_o), 32'd0);
        end
        rsp_ready_i = 4'b0100;
        tick();
        chk("bp_released", 32'(rsp_valid_o), 32'd0);
        chk("bp_idle_grant0", 32'(req_ready_o), 32'b0001);
        req_valid_i = '0;
        rsp_ready_i = '1;
        tick();

        // Illegal control code.
        run_op(1, 32'hFFFF_0000, 32'h0000_FFFF, 4'b1111, 4'b0000, 32'd0,
               1'b1, 1'b0, 1'b1, 1'b0);
        tick();

        // Reset during EXEC of requester 3.
        req_src1_i[3*DW +: DW] = 32'd5;
        req_src2_i[3*DW +: DW] = 32'd7;
        req_ctrl_i[3*4 +: 4]   = 4'b0010;
        req_valid_i[3]         = 1'b1;
        #1;
        chk("rst_op_grant3", 32'(req_ready_o), 32'b1000);
        tick();
        req_valid_i = '0;
        rst_i       = 1'b1;
        #1;
        chk("rst_op_alu_rst_n", 32'(alu_rst_n_o), 32'd0);
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rst_op_no_rsp", 32'(rsp_valid_o), 32'd0);
            tick();
        end

        // Pointer back at 0: requester 1 beats 3, then 3 is served.
        req_valid_i[3] = 1'b1;
        run_op(1, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0000, 4'b0000, 32'hF000_F000,
               1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        run_op(3, 32'd5, 32'd7, 4'b0010, 4'b0010, 32'd12, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Wrap: after a grant to 3, requester 0 wins over 3.
        req_valid_i[3] = 1'b1;
        run_op(0, 32'h0F0F_0000, 32'h0000_0F0F, 4'b0001, 4'b0001, 32'h0F0F_0F0F,
               1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        run_op(3, 32'd0, 32'd0, 4'b1100, 4'b1100, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        run_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1101, 4'b1101, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
